// File: rtl/clkdiv_pkg.sv
// Shared constants for the divider/tick controller: default sizing, reset taps
// and the datapath gating mode encoding.
package clkdiv_pkg;

    localparam int CNT_W    = 32;
    localparam int NCH      = 2;
    localparam int SEL_W    = 5;
    localparam int DEF_TAP0 = 17;
    localparam int DEF_TAP1 = 24;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_PAUSE = 2'b01,
        MODE_STEP  = 2'b10
    } mode_e;

endpackage

// File: rtl/clkdiv_tap_edge.sv
// One tick channel: programmable tap on the divider counter plus a rising-edge
// detector whose history bit is reloaded when the tap changes.
module clkdiv_tap_edge #(
    parameter int CNT_W   = clkdiv_pkg::CNT_W,
    parameter int SEL_W   = clkdiv_pkg::SEL_W,
    parameter int DEF_TAP = clkdiv_pkg::DEF_TAP0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] clkdiv,
    input  logic             load,
    input  logic [SEL_W-1:0] load_tap,
    output logic             raw
);

    logic [SEL_W-1:0] tap_reg;
    logic             prev_reg;
    logic             cur_bit;
    logic             new_bit;

    // Mask-and-reduce keeps every counter bit in use for the mux.
    assign cur_bit = |(clkdiv & (CNT_W'(1) << tap_reg));
    assign new_bit = |(clkdiv & (CNT_W'(1) << load_tap));
    assign raw     = cur_bit & ~prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_reg  <= SEL_W'(DEF_TAP);
            prev_reg <= 1'b0;
        end else if (load) begin
            // Seed history from the new tap so the switch itself is not an edge.
            tap_reg  <= load_tap;
            prev_reg <= new_bit;
        end else begin
            prev_reg <= cur_bit;
        end
    end

endmodule

// File: rtl/clkdiv_tick_ctrl.sv
// Free-running divider with per-channel tick taps; channels 1.. are gated by a
// RUN/PAUSE/STEP controller. Define CLKDIV_TICK_STEP_CNT_EN to add step_cnt.
module clkdiv_tick_ctrl #(
    parameter int CNT_W    = clkdiv_pkg::CNT_W,
    parameter int NCH      = clkdiv_pkg::NCH,
    parameter int SEL_W    = clkdiv_pkg::SEL_W,
    parameter int DEF_TAP0 = clkdiv_pkg::DEF_TAP0,
    parameter int DEF_TAP1 = clkdiv_pkg::DEF_TAP1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause,
    input  logic                    step_req,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [SEL_W-1:0]        cfg_tap,
    output logic                    cfg_err,
    output logic [CNT_W-1:0]        clkdiv,
`ifdef CLKDIV_TICK_STEP_CNT_EN
    output logic [15:0]             step_cnt,
`endif
    output logic [NCH-1:0]          tick,
    output logic [1:0]              mode
);

    import clkdiv_pkg::*;

    logic [CNT_W-1:0] cnt_reg;
    logic [NCH-1:0]   tick_reg;
    logic [NCH-1:0]   tick_next;
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   load;
    mode_e            mode_reg;
    logic             cfg_ready_reg;
    logic             cfg_err_reg;
    logic             accept;
    logic             ch_oob;
    logic             tap_oob;
    logic [SEL_W-1:0] tap_clamped;
    logic             step_fire;
    logic             gate_open;

    assign accept      = cfg_valid & cfg_ready_reg;
    assign ch_oob      = 32'(cfg_ch) >= 32'(NCH);
    assign tap_oob     = 32'(cfg_tap) >= 32'(CNT_W);
    assign tap_clamped = tap_oob ? SEL_W'(CNT_W - 1) : cfg_tap;

    // Channel 1 paces the step; all gated channels share its completion cycle.
    assign step_fire = (mode_reg == MODE_STEP) & raw[1];
    assign gate_open = (mode_reg == MODE_RUN) | step_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign load[gi] = accept & ~ch_oob & (32'(cfg_ch) == 32'(gi));

            clkdiv_tap_edge #(
                .CNT_W   (CNT_W),
                .SEL_W   (SEL_W),
                .DEF_TAP ((gi == 0) ? DEF_TAP0 : DEF_TAP1)
            ) u_edge (
                .clk      (clk),
                .rst      (rst),
                .clkdiv   (cnt_reg),
                .load     (load[gi]),
                .load_tap (tap_clamped),
                .raw      (raw[gi])
            );
        end
    endgenerate

    always_comb begin
        tick_next    = raw & {NCH{gate_open}};
        tick_next[0] = raw[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            tick_reg      <= '0;
            mode_reg      <= MODE_RUN;
            cfg_ready_reg <= 1'b1;
            cfg_err_reg   <= 1'b0;
        end else begin
            cnt_reg       <= cnt_reg + CNT_W'(1);
            tick_reg      <= tick_next;
            cfg_ready_reg <= ~accept;
            cfg_err_reg   <= accept & (ch_oob | tap_oob);
            case (mode_reg)
                MODE_RUN: begin
                    if (pause) mode_reg <= MODE_PAUSE;
                end
                MODE_PAUSE: begin
                    if (step_req)    mode_reg <= MODE_STEP;
                    else if (!pause) mode_reg <= MODE_RUN;
                end
                MODE_STEP: begin
                    if (raw[1]) mode_reg <= MODE_PAUSE;
                end
                default: mode_reg <= MODE_RUN;
            endcase
        end
    end

`ifdef CLKDIV_TICK_STEP_CNT_EN
    logic [15:0] step_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)            step_cnt_reg <= '0;
        else if (step_fire) step_cnt_reg <= step_cnt_reg + 16'd1;
    end

    assign step_cnt = step_cnt_reg;
`endif

    assign clkdiv    = cnt_reg;
    assign tick      = tick_reg;
    assign mode      = mode_reg;
    assign cfg_ready = cfg_ready_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_clkdiv_tick_ctrl.sv
// Self-checking bench for clkdiv_tick_ctrl: arithmetic tick model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_clkdiv_tick_ctrl;

    localparam int CNT_W    = 28;
    localparam int NCH      = 3;
    localparam int SEL_W    = 5;
    localparam int DEF_TAP0 = 17;
    localparam int DEF_TAP1 = 24;
    localparam int CH_W     = $clog2(NCH);
    localparam longint MOD  = longint'(1) << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             pause;
    logic             step_req;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [SEL_W-1:0] cfg_tap;
    logic             cfg_err;
    logic [CNT_W-1:0] clkdiv;
    logic [NCH-1:0]   tick;
    logic [1:0]       mode;
`ifdef CLKDIV_TICK_STEP_CNT_EN
    logic [15:0]      step_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clkdiv_tick_ctrl #(
        .CNT_W(CNT_W), .NCH(NCH), .SEL_W(SEL_W),
        .DEF_TAP0(DEF_TAP0), .DEF_TAP1(DEF_TAP1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause     (pause),
        .step_req  (step_req),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_tap   (cfg_tap),
        .cfg_err   (cfg_err),
        .clkdiv    (clkdiv),
`ifdef CLKDIV_TICK_STEP_CNT_EN
        .step_cnt  (step_cnt),
`endif
        .tick      (tick),
        .mode      (mode)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a tap-t channel has a rising edge whenever the counter
    // value is congruent to 2^t modulo 2^(t+1); ticks show one cycle later.
    longint         m_cnt;
    int             m_tap [NCH];
    int             m_mode;
    bit             m_ready;
    int             m_step;
    logic [NCH-1:0] e_tick;
    bit             e_err;
    bit [NCH-1:0]   m_raw;
    bit             m_open;
    bit             m_acc;

    int     t0_cnt = 0;
    int     t1_cnt = 0;
    bit     cap_en = 0;
    longint capq[$];

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_tap[0] = DEF_TAP0;
            for (int i = 1; i < NCH; i++) m_tap[i] = DEF_TAP1;
            m_mode  = 0;
            m_ready = 1;
            m_step  = 0;
            e_tick  = '0;
            e_err   = 0;
        end else begin
            for (int i = 0; i < NCH; i++)
                m_raw[i] = (m_cnt % (longint'(1) << (m_tap[i] + 1))) == (longint'(1) << m_tap[i]);
            m_open = (m_mode == 0) || (m_mode == 2 && m_raw[1]);
            for (int i = 0; i < NCH; i++)
                e_tick[i] = m_raw[i] && (i == 0 || m_open);
            if (m_mode == 2 && m_raw[1]) m_step = (m_step + 1) % 65536;
            case (m_mode)
                0: if (pause) m_mode = 1;
                1: if (step_req) m_mode = 2; else if (!pause) m_mode = 0;
                default: if (m_raw[1]) m_mode = 1;
            endcase
            m_acc = cfg_valid && m_ready;
            e_err = m_acc && (int'(cfg_tap) >= CNT_W || int'(cfg_ch) >= NCH);
            if (m_acc && int'(cfg_ch) < NCH)
                m_tap[cfg_ch] = (int'(cfg_tap) >= CNT_W) ? CNT_W - 1 : int'(cfg_tap);
            m_ready = !m_acc;
            m_cnt   = (m_cnt + 1) % MOD;
        end
        #1;
        check("clkdiv", clkdiv, m_cnt);
        check("tick", tick, e_tick);
        check("mode", mode, m_mode);
        check("cfg_ready", cfg_ready, m_ready);
        check("cfg_err", cfg_err, e_err);
`ifdef CLKDIV_TICK_STEP_CNT_EN
        check("step_cnt", step_cnt, m_step);
`endif
        if (tick[0]) t0_cnt++;
        if (tick[1]) t1_cnt++;
        if (tick[0] && cap_en) capq.push_back(longint'(clkdiv));
    end

    task automatic cfg_write(input int ch, input int tap, output logic err);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_tap   = SEL_W'(tap);
        @(negedge clk);
        cfg_valid = 1'b0;
        err       = cfg_err;
        @(negedge clk);
    endtask

    task automatic align(input int mask, input int val, input string name);
        int k;
        k = 0;
        while ((int'(clkdiv) & mask) != val && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(clkdiv) & mask, val);
    endtask

    initial begin
        logic err;
        rst = 1'b1; pause = 1'b0; step_req = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_tap = '0;
        repeat (3) @(negedge clk);
        check("reset_clkdiv", clkdiv, 0);
        check("reset_ready", cfg_ready, 1);

        // Tap0 = 2 written on the first cycle out of reset.
        rst = 1'b0; cfg_valid = 1'b1; cfg_ch = '0; cfg_tap = SEL_W'(2); cap_en = 1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("ready_low_after_accept", cfg_ready, 0);
        @(negedge clk);
        check("ready_back_high", cfg_ready, 1);
        repeat (23) @(negedge clk);
        cap_en = 0;
        check("tick0_capture_count", capq.size(), 3);
        if (capq.size() > 0) check("tick0_first", capq[0], 5);
        if (capq.size() > 1) check("tick0_second", capq[1], 13);
        if (capq.size() > 2) check("tick0_third", capq[2], 21);

        // RUN with tap1 = 1: one tick every 4 cycles.
        cfg_write(1, 1, err);
        repeat (10) @(negedge clk);
        t1_cnt = 0;
        repeat (16) @(negedge clk);
        check("run_tick1_rate", t1_cnt, 4);

        // PAUSE freezes gated ticks, channel 0 keeps running.
        pause = 1'b1;
        @(negedge clk);
        check("mode_pause", mode, 1);
        t0_cnt = 0; t1_cnt = 0;
        repeat (100) @(negedge clk);
        check("pause_no_tick1", t1_cnt, 0);
        check("pause_tick0_runs", t0_cnt >= 12, 1);

        // STEP with tap1 = 3; second request during STEP is ignored.
        cfg_write(1, 3, err);
        align(15, 9, "align_step");
        t1_cnt = 0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        check("mode_step", mode, 2);
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (25) @(negedge clk);
        check("step_single_tick", t1_cnt, 1);
        check("step_back_to_pause", mode, 1);

        // Reprogram tap1 3 -> 1 while bit 1 is already high.
        pause = 1'b0;
        repeat (2) @(negedge clk);
        align(3, 2, "align_reload");
        t1_cnt = 0;
        cfg_write(1, 1, err);
        repeat (2) @(negedge clk);
        check("reload_no_spurious", t1_cnt, 0);
        @(negedge clk);
        check("reload_first_tick", t1_cnt, 1);

        // Out-of-range tap clamps; out-of-range channel is dropped.
        cfg_write(1, 30, err);
        check("err_tap_clamp", err, 1);
        check("err_pulse_one_cycle", cfg_err, 0);
        cfg_write(3, 2, err);
        check("err_bad_channel", err, 1);
        cfg_write(1, 1, err);
        check("no_err_valid_write", err, 0);

        // Reset while a step is pending.
        pause = 1'b1;
        repeat (2) @(negedge clk);
        align(3, 3, "align_rst_step");
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_step_mode", mode, 0);
        check("rst_step_tick", tick, 0);
        check("rst_step_clkdiv", clkdiv, 0);
        rst = 1'b0;
        cfg_write(1, 1, err);
        repeat (3) @(negedge clk);

        // Three single steps.
        t1_cnt = 0;
        for (int s = 0; s < 3; s++) begin
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("three_steps_ticks", t1_cnt, 3);
`ifdef CLKDIV_TICK_STEP_CNT_EN
        check("three_steps_cnt", step_cnt, 3);
`endif

        // Random traffic against the model.
        pause = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(19) == 0) pause = ~pause;
            step_req  = ($urandom_range(15) == 0);
            cfg_valid = ($urandom_range(9) == 0);
            cfg_ch    = CH_W'($urandom_range(3));
            cfg_tap   = ($urandom_range(7) == 0) ? SEL_W'($urandom_range(31)) : SEL_W'($urandom_range(4));
            rst       = ($urandom_range(499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cfg_valid = 1'b0; step_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
